// File: rtl/alu4_arbiter_pkg.sv
// alu4_pkg: opcodes, FSM states and datapath widths shared by the ALU4 arbiter
package alu4_pkg;
  localparam int DATA_W = 4;
  localparam int RES_W = 8;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_MAX_VALID = 3'b101;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu4_arbiter_rr_picker.sv
// rr_picker: first valid requester at or above ptr, wrapping modulo N_REQ
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int ID_W = 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any_valid
);
  always_comb begin
    winner = '0;
    any_valid = |valid;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (valid[(int'(ptr) + k) % N_REQ]) winner = ID_W'((int'(ptr) + k) % N_REQ);
  end
endmodule

// File: rtl/alu4_arbiter.sv
// alu4_arbiter: round-robin sharing of one combinational ALU4 between N_REQ requesters
module alu4_arbiter
  import alu4_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [4*N_REQ-1:0]  req_a,
  input  logic [4*N_REQ-1:0]  req_b,
  input  logic [N_REQ-1:0]    req_cin,
  input  logic [3*N_REQ-1:0]  req_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic                alu_cin,
  output logic [2:0]          alu_op,
  input  logic [RES_W-1:0]    alu_out,
  input  logic                alu_cout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [RES_W-1:0]    rsp_out,
  output logic                rsp_cout,
  output logic                rsp_err
);
  state_t state;
  logic [ID_W-1:0] ptr, gid, winner;
  logic any_valid, grant, err;
  rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .valid(req_valid),
    .ptr(ptr),
    .winner(winner),
    .any_valid(any_valid)
  );
  always_comb begin
    grant = any_valid && (state == IDLE || (state == RESP && rsp_ready));
    req_ready = grant ? N_REQ'(1) << winner : '0;
    err = alu_op > OP_MAX_VALID;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      gid <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_cin <= 1'b0;
      alu_op <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_out <= '0;
      rsp_cout <= 1'b0;
      rsp_err <= 1'b0;
    end else if (grant) begin
      alu_a <= req_a[DATA_W*winner +: DATA_W];
      alu_b <= req_b[DATA_W*winner +: DATA_W];
      alu_cin <= req_cin[winner];
      alu_op <= req_op[3*winner +: 3];
      gid <= winner;
      ptr <= ID_W'((int'(winner) + 1) % N_REQ);
      rsp_valid <= 1'b0;
      state <= EXEC;
    end else if (state == EXEC) begin
      rsp_out <= err ? '0 : alu_out;
      rsp_cout <= err ? 1'b0 : alu_cout;
      rsp_err <= err;
      rsp_id <= gid;
      rsp_valid <= 1'b1;
      state <= RESP;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu4_arbiter.sv
// tb_alu4_arbiter: vector table, corner sequences and random scoreboard for alu4_arbiter
module tb_alu4_arbiter;
  import alu4_pkg::*;
  localparam int N = 4;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid, req_ready, req_cin;
  logic [4*N-1:0] req_a, req_b;
  logic [3*N-1:0] req_op;
  logic [3:0] alu_a, alu_b;
  logic alu_cin, alu_cout, rsp_valid, rsp_ready, rsp_cout, rsp_err;
  logic [2:0] alu_op;
  logic [7:0] alu_out, rsp_out;
  logic [IW-1:0] rsp_id;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {int id; logic [3:0] a, b; logic cin; logic [2:0] op; logic [7:0] out; logic cout, err;} vec_t;
  typedef struct {int t; int id; logic err; logic [8:0] r;} exp_t;
  vec_t vt[9];
  exp_t q[$];
  function automatic logic [8:0] alu_f(input logic [3:0] a, b, input logic cin, input logic [2:0] op);
    logic [7:0] r;
    logic c;
    c = 1'b0;
    case (op)
      OP_ADD: begin r = 8'(a) + 8'(b) + 8'(cin); c = r[4]; end
      OP_SUB: begin r = 8'(a) - 8'(b) - 8'(cin); c = int'(a) < int'(b) + int'(cin); end
      OP_AND: r = {4'h0, a & b};
      OP_OR:  r = {4'h0, a | b};
      OP_XOR: r = {4'h0, a ^ b};
      OP_MUL: r = 8'(a) * 8'(b);
      default: begin r = 8'hA5; c = 1'b1; end
    endcase
    return {c, r};
  endfunction
  assign {alu_cout, alu_out} = alu_f(alu_a, alu_b, alu_cin, alu_op);
  alu4_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_cout(rsp_cout), .rsp_err(rsp_err)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive(input int id, input logic [3:0] a, b, input logic cin, input logic [2:0] op);
    req_a[4*id +: 4] = a;
    req_b[4*id +: 4] = b;
    req_cin[id] = cin;
    req_op[3*id +: 3] = op;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    step;
    step;
    rst_n = 1'b1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_alu"}, {alu_a, alu_b, alu_cin, alu_op}, 0);
    check({tag, "_rsp"}, {rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_err}, 0);
  endtask
  task automatic run_vec(input vec_t v);
    req_valid = '0;
    drive(v.id, v.a, v.b, v.cin, v.op);
    req_valid[v.id] = 1'b1;
    #1;
    check("vec_ready", req_ready, 1 << v.id);
    step;
    req_valid = '0;
    check("vec_alu", {alu_a, alu_b, alu_cin, alu_op}, {v.a, v.b, v.cin, v.op});
    check("vec_exec_ready", req_ready, 0);
    check("vec_exec_valid", rsp_valid, 0);
    step;
    check("vec_rsp_valid", rsp_valid, 1);
    check("vec_rsp_id", rsp_id, v.id);
    check("vec_rsp", {rsp_out, rsp_cout, rsp_err}, {v.out, v.cout, v.err});
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    check("vec_idle", rsp_valid, 0);
  endtask
  initial begin
    int ptr, w, gw;
    int wt[N];
    logic exp_rv, can;
    logic [3:0] a, b;
    logic [2:0] op;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    req_op = '0;
    vt[0] = '{0, 4'h3, 4'h3, 1'b0, 3'b000, 8'h06, 1'b0, 1'b0};
    vt[1] = '{1, 4'hF, 4'hF, 1'b1, 3'b000, 8'h1F, 1'b1, 1'b0};
    vt[2] = '{2, 4'h5, 4'h3, 1'b0, 3'b001, 8'h02, 1'b0, 1'b0};
    vt[3] = '{3, 4'h3, 4'h5, 1'b0, 3'b001, 8'hFE, 1'b1, 1'b0};
    vt[4] = '{1, 4'hC, 4'hA, 1'b0, 3'b010, 8'h08, 1'b0, 1'b0};
    vt[5] = '{0, 4'hC, 4'hA, 1'b1, 3'b011, 8'h0E, 1'b0, 1'b0};
    vt[6] = '{2, 4'hC, 4'hA, 1'b0, 3'b100, 8'h06, 1'b0, 1'b0};
    vt[7] = '{3, 4'hF, 4'hF, 1'b0, 3'b101, 8'hE1, 1'b0, 1'b0};
    vt[8] = '{1, 4'h5, 4'h9, 1'b0, 3'b110, 8'h00, 1'b0, 1'b1};
    @(negedge clk);
    do_reset;
    check_zero("reset");
    for (int i = 0; i < 9; i++) run_vec(vt[i]);
    vt[0] = '{2, 4'h7, 4'h1, 1'b1, 3'b111, 8'h00, 1'b0, 1'b1};
    run_vec(vt[0]);
    // contention: 0 and 1 stay valid, grants must alternate every other cycle
    do_reset;
    drive(0, 4'h1, 4'h2, 1'b0, OP_ADD);
    drive(1, 4'h4, 4'h4, 1'b0, OP_ADD);
    req_valid = 4'b0011;
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("cont_ready", req_ready, c % 2 == 0 ? 1 << ((c / 2) % 2) : 0);
      check("cont_valid", rsp_valid, c >= 2 && c % 2 == 0);
      if (c >= 2 && c % 2 == 0) begin
        check("cont_id", rsp_id, ((c / 2) - 1) % 2);
        check("cont_out", rsp_out, ((c / 2) - 1) % 2 ? 8 : 3);
      end
      step;
    end
    req_valid = '0;
    step;
    step;
    rsp_ready = 1'b0;
    // backpressure with requester 1 pending
    drive(0, 4'h3, 4'h4, 1'b0, OP_ADD);
    req_valid = 4'b0001;
    #1;
    check("bp_ready0", req_ready, 4'b0001);
    step;
    drive(1, 4'h2, 4'h5, 1'b0, OP_MUL);
    req_valid = 4'b0010;
    check("bp_exec_ready", req_ready, 0);
    step;
    for (int c = 0; c < 5; c++) begin
      check("bp_hold", {rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_err}, {1'b1, 2'd0, 8'h07, 1'b0, 1'b0});
      check("bp_no_grant", req_ready, 0);
      step;
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_grant1", req_ready, 4'b0010);
    step;
    req_valid = '0;
    rsp_ready = 1'b0;
    step;
    check("bp_rsp1", {rsp_valid, rsp_id, rsp_out}, {1'b1, 2'd1, 8'h0A});
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    // reset while EXEC: response dropped, pointer back to 0
    drive(1, 4'h9, 4'h6, 1'b1, OP_XOR);
    req_valid = 4'b0010;
    step;
    req_valid = '0;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    check_zero("rst_exec");
    for (int c = 0; c < 3; c++) begin
      step;
      check("rst_no_rsp", rsp_valid, 0);
    end
    req_valid = 4'b0011;
    #1;
    check("rst_ptr0", req_ready, 4'b0001);
    step;
    req_valid = '0;
    step;
    check("rst_next", {rsp_valid, rsp_id}, {1'b1, 2'd0});
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    // random sweep against a queue/pointer scoreboard
    do_reset;
    ptr = 0;
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(9) < 4) begin
          drive(i, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)), 3'($urandom_range(7)));
          req_valid[i] = 1'b1;
        end
      rsp_ready = $urandom_range(9) < 7;
      #1;
      exp_rv = q.size() > 0 && c >= q[0].t + 2;
      can = |req_valid && (q.size() == 0 || (exp_rv && rsp_ready));
      w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
      check("rnd_rsp_valid", rsp_valid, exp_rv);
      check("rnd_ready", req_ready, can ? 1 << w : 0);
      if (exp_rv) begin
        check("rnd_id", rsp_id, q[0].id);
        check("rnd_rsp", {rsp_err, rsp_cout, rsp_out}, {q[0].err, q[0].r});
        if (rsp_ready) void'(q.pop_front());
      end
      gw = -1;
      if (can) begin
        a = req_a[4*w +: 4];
        b = req_b[4*w +: 4];
        op = req_op[3*w +: 3];
        q.push_back('{c, w, op > OP_MAX_VALID, op > OP_MAX_VALID ? 9'd0 : alu_f(a, b, req_cin[w], op)});
        check("rnd_fair", wt[w] <= N, 1);
        for (int j = 0; j < N; j++) if (j != w && req_valid[j]) wt[j]++;
        wt[w] = 0;
        ptr = (w + 1) % N;
        gw = w;
      end
      step;
      if (gw >= 0) req_valid[gw] = 1'b0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) step;
    check("drain_idle", rsp_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
